// File: rtl/uart_tx_control_module.sv
// ---------------------------------------------------------------------------
// uart_tx_control_module
//
// Byte-serial UART transmitter. Bytes arrive over a valid/ready handshake
// into a one-entry holding register and are sent LSB first as 8N1 frames.
// A frame can also be 8E1/8O1. An internal divider sets the bit timing.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When it is defined, a parity bit follows the data bits. PARITY_ODD picks
//   odd or even parity. When it is not defined, frames are 8N1 and
//   PARITY_ODD has no effect.
//
// Parameters:
//   BPS_DIV    clocks per bit period (>= 2)
//   STOP_BITS  number of stop bits (1 or 2)
//   PARITY_ODD 1 = odd parity, 0 = even parity
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   tx_en_sig    permits new frames to start; a frame already started
//                always completes
//   tx_valid     tx_data is valid this cycle
//   tx_data      byte to send
//   tx_ready     holding register is empty (forced low while rst is high)
//   tx_pin_out   registered serial line, idles high
//   tx_busy      high from START entry until the end of the final stop bit
//   tx_done_sig  one-cycle pulse in the first IDLE cycle after STOP
// ---------------------------------------------------------------------------
module uart_tx_control_module #(
  parameter int BPS_DIV    = 434,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en_sig,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_pin_out,
  output logic       tx_busy,
  output logic       tx_done_sig
);

  localparam int            TW         = $clog2(BPS_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BPS_DIV - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic          stop_idx_reg, stop_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    hold_data_reg, hold_data_next;
  logic          hold_full_reg, hold_full_next;
  logic          pin_reg, pin_next;
  logic          busy_reg;
  logic          done_reg;
  logic          timer_last;

`ifdef UART_TX_PARITY_EN
  logic          parity_reg, parity_next;
`else
  logic          unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  assign timer_last = (timer_reg == TIMER_LAST);

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg + TW'(1);
    bit_idx_next   = bit_idx_reg;
    stop_idx_next  = stop_idx_reg;
    shift_next     = shift_reg;
    hold_data_next = hold_data_reg;
    hold_full_next = hold_full_reg;
    pin_next       = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next    = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (hold_full_reg && tx_en_sig) begin
          shift_next     = hold_data_reg;
          hold_full_next = 1'b0;
`ifdef UART_TX_PARITY_EN
          // XOR of the data plus the odd flag gives odd parity when set
          parity_next    = (^hold_data_reg) ^ (PARITY_ODD != 0);
`endif
          state_next     = START;
        end
      end
      START: begin
        if (timer_last) begin
          timer_next   = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (timer_last) begin
          timer_next = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            stop_idx_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_next    = PARITY;
`else
            state_next    = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_last) begin
          timer_next    = '0;
          stop_idx_next = 1'b0;
          state_next    = STOP;
        end
      end
`endif
      STOP: begin
        // The bit timer only spans one bit, so a second stop bit is
        // counted separately.
        if (timer_last) begin
          timer_next = '0;
          if (stop_idx_reg == STOP_LAST) begin
            state_next = IDLE;
          end else begin
            stop_idx_next = stop_idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A launch needs a full buffer and an accept needs an empty one, so
    // these two updates never collide.
    if (tx_valid && !hold_full_reg) begin
      hold_full_next = 1'b1;
      hold_data_next = tx_data;
    end

    // The line register follows the state being entered, so the pin and
    // the FSM state always refer to the same cycle.
    case (state_next)
      START:   pin_next = 1'b0;
      DATA:    pin_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  pin_next = parity_reg;
`endif
      default: pin_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      bit_idx_reg   <= 3'd0;
      stop_idx_reg  <= 1'b0;
      shift_reg     <= 8'd0;
      hold_data_reg <= 8'd0;
      hold_full_reg <= 1'b0;
      pin_reg       <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      bit_idx_reg   <= bit_idx_next;
      stop_idx_reg  <= stop_idx_next;
      shift_reg     <= shift_next;
      hold_data_reg <= hold_data_next;
      hold_full_reg <= hold_full_next;
      pin_reg       <= pin_next;
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_reg == STOP) && (state_next == IDLE);
`ifdef UART_TX_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  // While rst is high the buffer is about to be cleared, so nothing is
  // offered to the upstream side.
  assign tx_ready    = !hold_full_reg && !rst;
  assign tx_pin_out  = pin_reg;
  assign tx_busy     = busy_reg;
  assign tx_done_sig = done_reg;

endmodule
